tick_spike_scheduler: RTL

Upstream stage of the LIF accelerator (Neuromorphic_design). Generates the global simulation tick from a programmable clock-cycle period. Buffers incoming input-spike events (neuron IDs) in a FIFO. On each tick it drains the spikes captured before that tick to the neuron core as a framed burst, marking the last event of each frame.

---
 rtl/tick_spike_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tick_spike_scheduler.sv
// rtl/tick_spike_scheduler.sv - tick generator and per-tick framed spike drain for the LIF accelerator
// Optional macro TICK_SPIKE_CNT_EN adds frame_spikes_o (frame length of the most recent tick).
module tick_spike_scheduler #(
  parameter int PERIOD_W       = 16,
  parameter int ID_W           = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [PERIOD_W-1:0]           cfg_period_i,
  input  logic                          cfg_period_we_i,
  input  logic                          spike_valid_i,
  input  logic [ID_W-1:0]               spike_id_i,
  output logic                          spike_ready_o,
  output logic                          tick_o,
  output logic                          out_valid_o,
  output logic [ID_W-1:0]               out_id_o,
  output logic                          out_last_o,
  input  logic                          out_ready_i,
  output logic [31:0]                   tick_count_o,
  output logic                          overrun_o,
`ifdef TICK_SPIKE_CNT_EN
  output logic [$clog2(FIFO_DEPTH):0]   frame_spikes_o,
`endif
  output logic                          drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic {S_COUNT, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d, pend_q, pend_d;
  logic [AW:0]         wptr_q, rptr_q, remain_q, remain_d, occ, frame_len;
  logic [ID_W-1:0]     mem_q [FIFO_DEPTH];
  logic                defer_q, defer_d, overrun_q, overrun_d, drop_q, drop_d;
  logic [31:0]         tick_cnt_q;
  logic                expiry, push, pop, full, tick;

  assign occ       = wptr_q - rptr_q;
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push      = spike_valid_i && !full;
  assign expiry    = enable_i && (cnt_q == period_q - PERIOD_W'(1));
  // Snapshot includes a spike accepted in the tick cycle itself.
  assign frame_len = occ + {{AW{1'b0}}, push};

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    defer_d     = defer_q;
    overrun_d   = overrun_q;
    tick        = 1'b0;
    pop         = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      S_COUNT: begin
        if (expiry || defer_q) begin
          tick     = 1'b1;
          defer_d  = 1'b0;
          remain_d = frame_len;
          if (frame_len != '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid_o = 1'b1;
        // Any number of expiries while draining collapse into one deferred tick.
        if (expiry) begin
          defer_d   = 1'b1;
          overrun_d = 1'b1;
        end
        if (out_ready_i) begin
          pop      = 1'b1;
          remain_d = remain_q - ONE;
          if (remain_q == ONE) state_d = S_COUNT;
        end
      end
      default: state_d = S_COUNT;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pend_d   = pend_q;
    drop_d   = drop_q | (spike_valid_i & full);
    if (enable_i) begin
      if (expiry) begin
        cnt_d    = '0;
        period_d = pend_q;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
    if (cfg_period_we_i)
      pend_d = (cfg_period_i < PERIOD_W'(2)) ? PERIOD_W'(2) : cfg_period_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_COUNT;
      cnt_q      <= '0;
      period_q   <= PERIOD_W'(DEFAULT_PERIOD);
      pend_q     <= PERIOD_W'(DEFAULT_PERIOD);
      wptr_q     <= '0;
      rptr_q     <= '0;
      remain_q   <= '0;
      defer_q    <= 1'b0;
      overrun_q  <= 1'b0;
      drop_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      pend_q    <= pend_d;
      remain_q  <= remain_d;
      defer_q   <= defer_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
      if (push) wptr_q <= wptr_q + ONE;
      if (pop) rptr_q <= rptr_q + ONE;
      if (tick) tick_cnt_q <= tick_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= spike_id_i;
  end

`ifdef TICK_SPIKE_CNT_EN
  logic [AW:0] frame_spikes_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) frame_spikes_q <= '0;
    else if (tick) frame_spikes_q <= frame_len;
  end
  assign frame_spikes_o = frame_spikes_q;
`endif

  // Head entry is only written when the FIFO wraps onto it, which cannot happen while full.
  assign out_id_o      = out_valid_o ? mem_q[rptr_q[AW-1:0]] : '0;
  assign out_last_o    = out_valid_o && (remain_q == ONE);
  assign spike_ready_o = !full;
  assign tick_o        = tick;
  assign tick_count_o  = tick_cnt_q;
  assign overrun_o     = overrun_q;
  assign drop_o        = drop_q;

endmodule
